// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline definitions: bubble encodings, controller FSM states and the
// per-cycle enable/flush bundle driven to the PC and pipeline registers.
package pipe_ctrl_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [4:0]  REG_ZERO  = 5'd0;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        FAULT = 2'd2
    } pipe_state_t;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_flush;
        logic ex_mem_en;
        logic mem_wb_en;
        logic mem_wb_flush;
    } pipe_ctrl_t;

    // Everything held, nothing flushed: used in reset, FAULT and as the freeze base.
    localparam pipe_ctrl_t CTRL_HOLD = '0;

    localparam pipe_ctrl_t CTRL_ADVANCE = '{
        pc_en:        1'b1,
        if_id_en:     1'b1,
        if_id_flush:  1'b0,
        id_ex_en:     1'b1,
        id_ex_flush:  1'b0,
        ex_mem_en:    1'b1,
        mem_wb_en:    1'b1,
        mem_wb_flush: 1'b0
    };

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard: the load in EX writes a register the ID instruction reads,
// so the loaded value is not yet available for forwarding.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    output logic       lu_hz
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);
    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign lu_hz   = ex_mem_read && (ex_rd != REG_ZERO) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Central hazard/stall controller: combinational enables and flushes for the
// PC and pipeline registers, a data-memory wait watchdog and a stall counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_br_taken,
    input  logic             mem_req,
    input  logic             dmem_ready,
    input  logic             imem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             mem_wb_flush,
    output logic             fault,
    output logic [CNT_W-1:0] stall_cnt
);

    // One extra bit so the counter can hold TIMEOUT on the cycle it trips.
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    pipe_state_t       state;
    pipe_state_t       state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              dfreeze;
    logic              lu_hz;
    pipe_ctrl_t        ctrl;

    assign dfreeze = mem_req && !dmem_ready;

    hazard_detect u_hazard_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .lu_hz       (lu_hz)
    );

    // NOTE: every field gets a default before the priority chain, so no branch can infer a latch.
    always_comb begin
        ctrl = CTRL_ADVANCE;
        if (rst || state == FAULT) begin
            ctrl = CTRL_HOLD;
        end else if (dfreeze) begin
            ctrl              = CTRL_HOLD;
            ctrl.mem_wb_flush = 1'b1;
        end else if (ex_br_taken) begin
            ctrl.if_id_flush = 1'b1;
            ctrl.id_ex_flush = 1'b1;
        end else if (lu_hz) begin
            ctrl.pc_en       = 1'b0;
            ctrl.if_id_en    = 1'b0;
            ctrl.id_ex_flush = 1'b1;
        end else if (!imem_ready) begin
            ctrl.pc_en       = 1'b0;
            ctrl.if_id_flush = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:   if (dfreeze) state_next = WAIT;
            WAIT: begin
                if (!dfreeze)
                    state_next = RUN;
                else if (wait_cnt == WAIT_W'(TIMEOUT - 1))
                    state_next = FAULT;
            end
            FAULT: state_next = FAULT;
            default: state_next = RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            state <= state_next;
            if (state != FAULT) begin
                if (dfreeze)
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                else
                    wait_cnt <= '0;
                if (!ctrl.pc_en && stall_cnt != '1)
                    stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    assign pc_en        = ctrl.pc_en;
    assign if_id_en     = ctrl.if_id_en;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_en     = ctrl.id_ex_en;
    assign id_ex_flush  = ctrl.id_ex_flush;
    assign ex_mem_en    = ctrl.ex_mem_en;
    assign mem_wb_en    = ctrl.mem_wb_en;
    assign mem_wb_flush = ctrl.mem_wb_flush;
    assign fault        = (state == FAULT);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: a cycle-level behavioural model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_pipe_ctrl;

    localparam int unsigned TIMEOUT   = 8;
    localparam int unsigned CNT_W     = 3;
    localparam int          STALL_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       ex_rd;
    logic             ex_mem_read;
    logic             ex_br_taken;
    logic             mem_req;
    logic             dmem_ready;
    logic             imem_ready;
    logic             pc_en;
    logic             if_id_en;
    logic             if_id_flush;
    logic             id_ex_en;
    logic             id_ex_flush;
    logic             ex_mem_en;
    logic             mem_wb_en;
    logic             mem_wb_flush;
    logic             fault;
    logic [CNT_W-1:0] stall_cnt;

    int compared   = 0;
    int mismatched = 0;

    pipe_ctrl #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .ex_rd        (ex_rd),
        .ex_mem_read  (ex_mem_read),
        .ex_br_taken  (ex_br_taken),
        .mem_req      (mem_req),
        .dmem_ready   (dmem_ready),
        .imem_ready   (imem_ready),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .if_id_flush  (if_id_flush),
        .id_ex_en     (id_ex_en),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_en    (ex_mem_en),
        .mem_wb_en    (mem_wb_en),
        .mem_wb_flush (mem_wb_flush),
        .fault        (fault),
        .stall_cnt    (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    bit m_fault  = 1'b0;
    int m_frozen = 0;
    int m_stall  = 0;

    always @(negedge clk) begin
        bit frz, hz;
        bit e_pc, e_ifen, e_iffl, e_idexen, e_idexfl, e_exmem, e_mwen, e_mwfl;

        frz = mem_req && !dmem_ready;
        hz  = ex_mem_read && (ex_rd != 5'd0) &&
              ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));

        {e_pc, e_ifen, e_idexen, e_exmem, e_mwen} = 5'b11111;
        {e_iffl, e_idexfl, e_mwfl}               = 3'b000;
        if (rst || m_fault) begin
            {e_pc, e_ifen, e_idexen, e_exmem, e_mwen} = 5'b00000;
        end else if (frz) begin
            {e_pc, e_ifen, e_idexen, e_exmem, e_mwen} = 5'b00000;
            e_mwfl = 1'b1;
        end else if (ex_br_taken) begin
            e_iffl   = 1'b1;
            e_idexfl = 1'b1;
        end else if (hz) begin
            e_pc     = 1'b0;
            e_ifen   = 1'b0;
            e_idexfl = 1'b1;
        end else if (!imem_ready) begin
            e_pc   = 1'b0;
            e_iffl = 1'b1;
        end

        check("pc_en", pc_en, e_pc);
        check("if_id_flush", if_id_flush, e_iffl);
        check("id_ex_flush", id_ex_flush, e_idexfl);
        check("mem_wb_flush", mem_wb_flush, e_mwfl);
        check("ex_mem_en", ex_mem_en, e_exmem);
        if (!e_iffl)   check("if_id_en", if_id_en, e_ifen);
        if (!e_idexfl) check("id_ex_en", id_ex_en, e_idexen);
        if (!e_mwfl)   check("mem_wb_en", mem_wb_en, e_mwen);
        check("fault", fault, m_fault);
        check("stall_cnt", stall_cnt, m_stall);

        // Advance the model to the value it must hold after the next rising edge.
        if (rst) begin
            m_fault  = 1'b0;
            m_frozen = 0;
            m_stall  = 0;
        end else if (!m_fault) begin
            if (!e_pc && m_stall < STALL_MAX) m_stall++;
            if (frz) begin
                m_frozen++;
                if (m_frozen == TIMEOUT) m_fault = 1'b1;
            end else begin
                m_frozen = 0;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1      = 5'd0;
        id_rs2      = 5'd0;
        id_use_rs1  = 1'b0;
        id_use_rs2  = 1'b0;
        ex_rd       = 5'd0;
        ex_mem_read = 1'b0;
        ex_br_taken = 1'b0;
        mem_req     = 1'b0;
        dmem_ready  = 1'b1;
        imem_ready  = 1'b1;
    endtask

    task automatic load_use_rs1();
        ex_mem_read = 1'b1;
        ex_rd       = 5'd5;
        id_rs1      = 5'd5;
        id_use_rs1  = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        tick();
        @(negedge clk);
        check("lit_rst_pc_en", pc_en, 1'b0);
        check("lit_rst_mem_wb_flush", mem_wb_flush, 1'b0);
        check("lit_rst_stall", stall_cnt, 0);

        tick();
        rst = 1'b0;
        @(negedge clk);
        check("lit_run_pc_en", pc_en, 1'b1);

        // Load-use on rs1: one bubble.
        tick();
        load_use_rs1();
        @(negedge clk);
        check("lit_lu_pc_en", pc_en, 1'b0);
        check("lit_lu_if_id_en", if_id_en, 1'b0);
        check("lit_lu_id_ex_flush", id_ex_flush, 1'b1);
        check("lit_lu_ex_mem_en", ex_mem_en, 1'b1);
        tick();
        idle();
        @(negedge clk);
        check("lit_lu_after_pc_en", pc_en, 1'b1);
        check("lit_lu_after_stall", stall_cnt, 1);

        // Load to x0 never stalls.
        tick();
        ex_mem_read = 1'b1;
        @(negedge clk);
        check("lit_x0_pc_en", pc_en, 1'b1);

        // Matching rs1 that the instruction does not read.
        tick();
        load_use_rs1();
        id_use_rs1 = 1'b0;
        @(negedge clk);
        check("lit_unused_rs1_pc_en", pc_en, 1'b1);

        // Hazard through rs2 instead.
        tick();
        id_rs2     = 5'd5;
        id_use_rs2 = 1'b1;
        @(negedge clk);
        check("lit_rs2_pc_en", pc_en, 1'b0);
        tick();
        idle();
        @(negedge clk);
        check("lit_rs2_stall", stall_cnt, 2);

        // Taken branch masks both load-use and an instruction-memory miss.
        tick();
        load_use_rs1();
        ex_br_taken = 1'b1;
        imem_ready  = 1'b0;
        @(negedge clk);
        check("lit_br_pc_en", pc_en, 1'b1);
        check("lit_br_if_id_flush", if_id_flush, 1'b1);
        check("lit_br_id_ex_flush", id_ex_flush, 1'b1);
        tick();
        idle();
        @(negedge clk);
        check("lit_br_stall", stall_cnt, 2);

        // Data-memory freeze for 3 cycles with a branch pending.
        tick();
        rst = 1'b1;
        tick();
        rst         = 1'b0;
        mem_req     = 1'b1;
        dmem_ready  = 1'b0;
        ex_br_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("lit_frz_pc_en", pc_en, 1'b0);
            check("lit_frz_mem_wb_flush", mem_wb_flush, 1'b1);
            check("lit_frz_if_id_flush", if_id_flush, 1'b0);
            tick();
        end
        dmem_ready = 1'b1;
        @(negedge clk);
        check("lit_frz_br_pc_en", pc_en, 1'b1);
        check("lit_frz_br_if_id_flush", if_id_flush, 1'b1);
        check("lit_frz_br_mem_wb_flush", mem_wb_flush, 1'b0);
        check("lit_frz_stall", stall_cnt, 3);

        // Instruction-memory miss for 2 cycles: front end bubbles, back end advances.
        tick();
        idle();
        imem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("lit_imiss_pc_en", pc_en, 1'b0);
            check("lit_imiss_if_id_flush", if_id_flush, 1'b1);
            check("lit_imiss_id_ex_en", id_ex_en, 1'b1);
            check("lit_imiss_mem_wb_en", mem_wb_en, 1'b1);
            tick();
        end
        imem_ready = 1'b1;
        @(negedge clk);
        check("lit_imiss_stall", stall_cnt, 5);

        // Watchdog: a released freeze restarts the count; 8 frozen cycles then trip.
        tick();
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        mem_req    = 1'b1;
        dmem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("lit_wd_pre_fault", fault, 1'b0);
            tick();
        end
        dmem_ready = 1'b1;
        @(negedge clk);
        check("lit_wd_release_pc_en", pc_en, 1'b1);
        tick();
        dmem_ready = 1'b0;
        for (int i = 0; i < int'(TIMEOUT); i++) begin
            @(negedge clk);
            check("lit_wd_frozen_fault", fault, 1'b0);
            tick();
        end
        @(negedge clk);
        check("lit_wd_fault", fault, 1'b1);
        check("lit_wd_pc_en", pc_en, 1'b0);
        check("lit_wd_mem_wb_flush", mem_wb_flush, 1'b0);
        check("lit_wd_stall_sat", stall_cnt, STALL_MAX);
        tick();
        idle();
        @(negedge clk);
        check("lit_wd_absorb_fault", fault, 1'b1);
        check("lit_wd_absorb_pc_en", pc_en, 1'b0);
        check("lit_wd_absorb_stall", stall_cnt, STALL_MAX);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("lit_wd_rst_fault", fault, 1'b0);
        check("lit_wd_rst_stall", stall_cnt, 0);
        check("lit_wd_rst_pc_en", pc_en, 1'b1);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central hazard and stall controller for the 5-stage pipeline. Each cycle it decides enable (hold) and flush (bubble) for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Inputs are load-use hazards, taken branches, instruction/data memory wait states, and a memory-wait watchdog. It also keeps a stall-cycle performance counter and a sticky fault flag.

## Interface
- `TIMEOUT`, 64: frozen data-memory wait cycles before fault.
- `CNT_W`, 32: width of stall counter.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `id_rs1`, `id_rs2` in 5 each: source registers of the instruction in ID.
- `id_use_rs1`, `id_use_rs2` in 1 each: ID instruction reads that source.
- `ex_rd` in 5: destination of the instruction in EX.
- `ex_mem_read` in 1: EX instruction is a load.
- `ex_br_taken` in 1: EX resolved a taken branch or jump (PC redirect).
- `mem_req` in 1: MEM-stage instruction accesses data memory.
- `dmem_ready` in 1: data memory completes the access this cycle.
- `imem_ready` in 1: instruction memory returns a valid word this cycle.
- `pc_en` out 1: PC register load enable.
- `if_id_en`, `if_id_flush` out 1 each.
- `id_ex_en`, `id_ex_flush` out 1 each.
- `ex_mem_en` out 1.
- `mem_wb_en`, `mem_wb_flush` out 1 each.
- `fault` out 1: sticky watchdog fault.
- `stall_cnt` out `CNT_W`: count of cycles with `pc_en`=0.

## Operation
- Flush is a synchronous clear of the target register to a NOP/zero bubble. When flush=1, the matching en is don't-care; flush wins.
- `dfreeze` = `mem_req & ~dmem_ready`.
- `lu_hz` = `ex_mem_read & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd))`.
- Priority per cycle, highest first:
  - FAULT state: all en=0, all flush=0. Pipeline is frozen until `rst`.
  - `dfreeze`: `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en` = 0; `mem_wb_flush`=1. Branch and load-use are ignored this cycle and re-evaluated next cycle.
  - `ex_br_taken`: `pc_en`=1 (loads target); `if_id_flush`=1; `id_ex_flush`=1; other en=1.
  - `lu_hz`: `pc_en`=0; `if_id_en`=0; `id_ex_flush`=1; `ex_mem_en`, `mem_wb_en` = 1.
  - `~imem_ready`: `pc_en`=0; `if_id_flush`=1; downstream en=1.
  - Otherwise: all en=1, all flush=0.
- A taken branch masks simultaneous `lu_hz` and `~imem_ready`, because the ID instruction is squashed.
- FSM states:
  - RUN → WAIT when `dfreeze`.
  - WAIT → RUN when `~dfreeze`.
  - WAIT → FAULT when `dfreeze` and `wait_cnt` == `TIMEOUT`-1.
  - FAULT is absorbing; only `rst` leaves it.
- `wait_cnt`: cleared on entering RUN. Increments on every `dfreeze` cycle, including the RUN cycle that enters WAIT.
- `fault` = (state == FAULT).
- `stall_cnt`: increments when `pc_en`=0 and not FAULT. Saturates at all-ones with no wrap.

## Timing
- Enables and flushes are combinational from the current state and inputs, with no latency, so the pipeline registers act on the same edge.
- State, `wait_cnt` and `stall_cnt` update on `posedge clk`.
- Reset values (while `rst`=1, and the cycle after): state RUN, `wait_cnt`=0, `stall_cnt`=0, `fault`=0.
- While `rst`=1, all en=0 and all flush=0, since the pipeline registers are reset directly.
- Load-use costs exactly one bubble; the next cycle `lu_hz` drops because the load has moved to MEM.
- Taken branch costs two bubbles (IF/ID, ID/EX).
- Fault asserts on the cycle after the `TIMEOUT`-th consecutive frozen cycle.
- `dmem_ready` in the same cycle as `mem_req` means no freeze.
- `rst` mid-WAIT or in FAULT returns to RUN and clears the counters.

## Structure
- Shared pipeline package: `NOP_INSTR` (32'h00000013), `REG_ZERO` (5'd0), and an FSM state enum {`RUN`, `WAIT`, `FAULT`}.
- The existing pipeline registers take flush as an extra synchronous clear, OR-ed with `rst` at instantiation.
- One natural sub-module, `hazard_detect`: combinational `lu_hz` comparison. Everything else lives in `pipe_ctrl`.

## Test plan
- Load x5 in EX, ID reads rs1=x5 → one cycle with `pc_en`=0, `if_id_en`=0, `id_ex_flush`=1; normal next cycle; `stall_cnt`=1.
- Same as above with `ex_rd`=0 → no stall. With `id_use_rs1`=0 → no stall.
- `ex_br_taken`=1 together with `lu_hz`=1 → `pc_en`=1, `if_id_flush`=1, `id_ex_flush`=1; `stall_cnt` unchanged.
- `mem_req`=1 with `dmem_ready` low for 3 cycles and `ex_br_taken` held =1 → 3 frozen cycles with `mem_wb_flush`=1. Then the branch flush happens in the 4th cycle; `stall_cnt`=3.
- `TIMEOUT`=8, `dmem_ready` held 0 → `fault`=1 at cycle 9 and all en stay 0. `rst` → `fault`=0, `stall_cnt`=0, state RUN.
- `imem_ready`=0 for 2 cycles → `pc_en`=0 and `if_id_flush`=1 for both cycles, downstream stages keep advancing.
